// File: rtl/gate_selftest_seq_if.sv
// Bundle between the gate self-test engine and its environment: run control, gate results, verdict.
// The failure-log signals exist only when GATE_SELFTEST_FAILLOG_EN is defined.
interface gate_selftest_seq_if #(
   parameter int CNT_W = 4
);
   logic             start;
   logic [7:0]       res;
   logic             a;
   logic             b;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] err_cnt;
`ifdef GATE_SELFTEST_FAILLOG_EN
   logic [1:0]       first_fail_vec;
   logic [7:0]       first_fail_mask;

   modport master (
      output start, res,
      input  a, b, busy, done, pass, err_cnt, first_fail_vec, first_fail_mask
   );
   modport slave (
      input  start, res,
      output a, b, busy, done, pass, err_cnt, first_fail_vec, first_fail_mask
   );
`else
   modport master (
      output start, res,
      input  a, b, busy, done, pass, err_cnt
   );
   modport slave (
      input  start, res,
      output a, b, busy, done, pass, err_cnt
   );
`endif
endinterface

// File: rtl/gate_selftest_seq.sv
// Self-test sequencer for the 2-input gate block; optional first-failure log under GATE_SELFTEST_FAILLOG_EN.
// Run takes LOOPS*4*(SETTLE_CYCLES+1)+1 cycles from start to done; start is ignored while busy.
module gate_selftest_seq #(
   parameter int SETTLE_CYCLES = 2,
   parameter int LOOPS         = 1,
   parameter int CNT_W         = 4
) (
   input logic          clk,
   input logic          rst_n,
   gate_selftest_seq_if.slave st
);
   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [3:0]       LOOP_LAST   = 4'(LOOPS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   state_t           state, state_nx;
   logic [1:0]       idx, idx_nx;
   logic [3:0]       loop_cnt, loop_nx;
   logic [3:0]       settle, settle_nx;
   logic [CNT_W-1:0] err, err_nx;
   logic [7:0]       exp_res;
   logic             mism;
`ifdef GATE_SELFTEST_FAILLOG_EN
   logic [1:0]       ffv, ffv_nx;
   logic [7:0]       ffm, ffm_nx;
`endif

   // Golden truth table, bit order {xnor,nor,nand,xor,or,and,notb,nota}
   always_comb begin
      exp_res = 8'hE3;
      case (idx)
         2'd0: exp_res = 8'hE3;
         2'd1: exp_res = 8'h39;
         2'd2: exp_res = 8'h3A;
         2'd3: exp_res = 8'h8C;
         default: exp_res = 8'hE3;
      endcase
   end

   assign mism = (st.res != exp_res);

   always_comb begin
      state_nx  = state;
      idx_nx    = idx;
      loop_nx   = loop_cnt;
      settle_nx = settle;
      err_nx    = err;
`ifdef GATE_SELFTEST_FAILLOG_EN
      ffv_nx    = ffv;
      ffm_nx    = ffm;
`endif
      case (state)
         IDLE, DONE: begin
            if (st.start) begin
               state_nx  = DRIVE;
               idx_nx    = 2'd0;
               loop_nx   = 4'd0;
               settle_nx = 4'd0;
               err_nx    = '0;
`ifdef GATE_SELFTEST_FAILLOG_EN
               ffv_nx    = 2'd0;
               ffm_nx    = 8'd0;
`endif
            end
         end
         DRIVE: begin
            if (settle == SETTLE_LAST) begin
               state_nx  = SAMPLE;
               settle_nx = 4'd0;
            end else begin
               settle_nx = settle + 4'd1;
            end
         end
         SAMPLE: begin
            if (mism) begin
               if (err != CNT_MAX) err_nx = err + CNT_W'(1);
`ifdef GATE_SELFTEST_FAILLOG_EN
               // err still zero means this is the first mismatch of the run
               if (err == '0) begin
                  ffv_nx = idx;
                  ffm_nx = exp_res ^ st.res;
               end
`endif
            end
            if (idx != 2'd3) begin
               idx_nx   = idx + 2'd1;
               state_nx = DRIVE;
            end else if (loop_cnt != LOOP_LAST) begin
               idx_nx   = 2'd0;
               loop_nx  = loop_cnt + 4'd1;
               state_nx = DRIVE;
            end else begin
               state_nx = DONE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= 2'd0;
         loop_cnt <= 4'd0;
         settle   <= 4'd0;
         err      <= '0;
`ifdef GATE_SELFTEST_FAILLOG_EN
         ffv      <= 2'd0;
         ffm      <= 8'd0;
`endif
      end else begin
         state    <= state_nx;
         idx      <= idx_nx;
         loop_cnt <= loop_nx;
         settle   <= settle_nx;
         err      <= err_nx;
`ifdef GATE_SELFTEST_FAILLOG_EN
         ffv      <= ffv_nx;
         ffm      <= ffm_nx;
`endif
      end
   end

   // The index register is the stimulus; it only moves on edges entering DRIVE
   assign st.a       = idx[1];
   assign st.b       = idx[0];
   assign st.busy    = (state == DRIVE) || (state == SAMPLE);
   assign st.done    = (state == DONE);
   assign st.pass    = (state == DONE) && (err == '0);
   assign st.err_cnt = err;
`ifdef GATE_SELFTEST_FAILLOG_EN
   assign st.first_fail_vec  = ffv;
   assign st.first_fail_mask = ffm;
`endif
endmodule

// File: doc/gate_selftest_seq.md
Name: gate_selftest_seq

Overview:
- Sequential self-test engine for the two-input combinational gate block (inputs a, b; outputs NOT a, NOT b, AND, OR, XOR, NAND, NOR, XNOR).
- Sits directly around that block: it drives the block's a/b inputs with all four input combinations and consumes its eight outputs.
- It compares each output against the truth table and reports pass/fail plus an error count. The result is usable on silicon and in simulation without a hand-written stimulus bench.

Parameters:
- SETTLE_CYCLES, 2: clock cycles each vector is held before the outputs are sampled (1..15).
- LOOPS, 1: number of full 4-vector passes per run (1..15).
- CNT_W, 4: width of err_cnt; the counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle run request; sampled only in IDLE or DONE.
- res  in  8  gate outputs. Bit order: [0]=c_nota, [1]=c_notb, [2]=c_and, [3]=c_or, [4]=c_xor, [5]=c_nand, [6]=c_nor, [7]=c_xnor.
- a  out  1  stimulus to gate block input a (registered).
- b  out  1  stimulus to gate block input b (registered).
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until the next start or reset.
- pass  out  1  valid while done=1; high iff err_cnt==0.
- err_cnt  out  CNT_W  number of mismatching vector samples in the current or last run.

Behaviour:
- Reset (async assert, sync release):
  - a=0, b=0, busy=0, done=0, pass=0, err_cnt=0.
  - FSM=IDLE, vector index=0, loop count=0, settle counter=0.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: on start=1, go to DRIVE. Clear err_cnt, index and loop count, and set busy=1 on the next edge.
- DRIVE: {a,b} = index, i.e. 00, 01, 10, 11 in order.
  - a/b are registered and update on the edge entering DRIVE.
  - Settle counter counts SETTLE_CYCLES cycles, then the FSM goes to SAMPLE.
  - Effective hold time before sampling is exactly SETTLE_CYCLES clocks after a/b change.
- SAMPLE: one cycle. Compare res with the expected value for {a,b}:
  - 00 -> 8'hE3
  - 01 -> 8'h39
  - 10 -> 8'h3A
  - 11 -> 8'h8C
- On mismatch, err_cnt increments by 1, saturating at all-ones. One increment per vector sample regardless of how many bits differ.
- Next-state decision after SAMPLE:
  - index<3: index+1, go to DRIVE.
  - index==3 and loop count<LOOPS-1: index=0, loop count+1, go to DRIVE.
  - Otherwise: go to DONE.
- DONE: busy=0, done=1, pass=(err_cnt==0). a/b hold the last vector (11).
  - start in DONE behaves as in IDLE: clears done/pass/err_cnt and starts a new run.
- start while busy=1 is ignored and has no effect on state or counters.
- Run length in cycles, start to done=1: LOOPS*4*(SETTLE_CYCLES+1)+1.
- Reset mid-run: immediate abort to reset values. No partial results are retained.
- res is assumed stable during SAMPLE. No synchronisation is applied; the gate block shares clk's domain.

Optional Feature:
- Macro: GATE_SELFTEST_FAILLOG_EN.
- Defined:
  - Adds output first_fail_vec (2 bits): the {a,b} value of the first mismatching sample in the run.
  - Adds output first_fail_mask (8 bits): expected XOR res for that sample.
  - Both are captured once per run and cleared to 0 on reset and on each accepted start.
  - They remain 0 if the run passes.
- Not defined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Ideal gate model, defaults, start pulse -> a/b step through 00, 01, 10, 11, each held 2 cycles. done=1 at cycle 13 after start, pass=1, err_cnt=0.
- Model with c_xor stuck at 0 -> mismatches at vectors 01 and 10, so err_cnt=2 and pass=0. With FAILLOG_EN: first_fail_vec=01, first_fail_mask=8'h10.
- LOOPS=3, CNT_W=2, res forced to 8'h00 -> 12 mismatches and err_cnt saturates at 3. done appears after 37 cycles.
- start pulsed again at cycle 5 of a run -> ignored: vector order and done timing unchanged, err_cnt not cleared.
- rst_n low during SAMPLE of vector 10 -> outputs return immediately to reset values. A subsequent start runs a full clean sequence with pass=1.
- SETTLE_CYCLES=1, start pulsed while done=1 -> done/pass/err_cnt clear on the next edge, and a new run completes in 9 cycles.
